// File: rtl/issue_unit.sv
// issue_unit: in-order issue stage for the Tomasulo core.
// It pops one instruction from the instruction queue and reads both source
// operands (tag + value) from the register file, snooping the CDB while it
// does so. It then allocates a free reservation station and renames the
// destination register to that station's tag.
//
// Optional feature macro: ISSUE_RR_ALLOC_EN
//   defined   -> round-robin station allocation (last-allocated pointer)
//   undefined -> fixed priority, lowest free station index wins
//
// Tag 0 means "value ready"; station i (0-based) owns tag i+1.
module issue_unit #(
    parameter int DATA_W    = 16,
    parameter int INSTR_W   = 16,
    parameter int NUM_RS    = 4,
    parameter int TAG_W     = 3,
    parameter int REG_IDX_W = 3
) (
    input  logic                 CLK,
    input  logic                 CLR,
    // instruction queue
    input  logic                 q_empty,
    output logic                 q_rd,
    input  logic [INSTR_W-1:0]   q_instr,
    // register file read ports
    output logic [REG_IDX_W-1:0] rf_rd0_idx,
    output logic [REG_IDX_W-1:0] rf_rd1_idx,
    input  logic [TAG_W-1:0]     rf_rd0_tag,
    input  logic [TAG_W-1:0]     rf_rd1_tag,
    input  logic [DATA_W-1:0]    rf_rd0_data,
    input  logic [DATA_W-1:0]    rf_rd1_data,
    // register file rename port
    output logic                 rf_wren,
    output logic [REG_IDX_W-1:0] rf_wr_idx,
    output logic [TAG_W-1:0]     rf_wr_tag,
    // reservation stations
    input  logic [NUM_RS-1:0]    rs_busy,
    output logic [NUM_RS-1:0]    rs_start,
    output logic [INSTR_W-1:0]   rs_instr,
    output logic [TAG_W-1:0]     rs_tag0,
    output logic [TAG_W-1:0]     rs_tag1,
    output logic [DATA_W-1:0]    rs_data0,
    output logic [DATA_W-1:0]    rs_data1,
    // common data bus
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_data,
    // statistics
    output logic [15:0]          issued_cnt,
    output logic [15:0]          stall_cnt
);

    localparam int SEL_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_ALLOC
    } state_t;

    // One source operand: a producer tag (0 = ready) and its value.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } operand_t;

    // Replace a pending operand by the CDB value when its producer broadcasts.
    function automatic operand_t snoop(
        input operand_t            op,
        input logic                valid,
        input logic [TAG_W-1:0]    tag,
        input logic [DATA_W-1:0]   data
    );
        operand_t res;
        res = op;
        if (valid && (op.tag != '0) && (tag == op.tag)) begin
            res.tag  = '0;
            res.data = data;
        end
        return res;
    endfunction

    state_t            state;
    state_t            next_state;
    logic [INSTR_W-1:0] ir;
    operand_t          op0;
    operand_t          op1;
    operand_t          rf_op0;
    operand_t          rf_op1;
    operand_t          op0_byp;
    operand_t          op1_byp;
    operand_t          rs_op0;
    operand_t          rs_op1;
    logic              found;
    logic [SEL_W-1:0]  sel_idx;

    // Register file indices come straight from the instruction register.
    assign rf_rd0_idx = ir[3 +: REG_IDX_W];
    assign rf_rd1_idx = ir[6 +: REG_IDX_W];
    assign rf_wr_idx  = ir[3 +: REG_IDX_W];
    assign rs_instr   = ir;

    // Operand candidates: fresh register-file reads and latched operands,
    // both with a same-cycle CDB bypass applied.
    assign rf_op0  = snoop({rf_rd0_tag, rf_rd0_data}, cdb_valid, cdb_tag, cdb_data);
    assign rf_op1  = snoop({rf_rd1_tag, rf_rd1_data}, cdb_valid, cdb_tag, cdb_data);
    assign op0_byp = snoop(op0, cdb_valid, cdb_tag, cdb_data);
    assign op1_byp = snoop(op1, cdb_valid, cdb_tag, cdb_data);

    // The bypass is only visible while allocating; the ALLOC-cycle snoop
    // writes the same value back, so the outputs hold steady afterwards.
    assign rs_op0   = (state == S_ALLOC) ? op0_byp : op0;
    assign rs_op1   = (state == S_ALLOC) ? op1_byp : op1;
    assign rs_tag0  = rs_op0.tag;
    assign rs_data0 = rs_op0.data;
    assign rs_tag1  = rs_op1.tag;
    assign rs_data1 = rs_op1.data;

`ifdef ISSUE_RR_ALLOC_EN
    logic [SEL_W-1:0] rr_ptr;

    // Round-robin search: start one past the last allocated station and wrap.
    always_comb begin
        int cand;
        found   = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_RS; k++) begin
            cand = int'(rr_ptr) + 1 + k;
            if (cand >= NUM_RS) begin
                cand = cand - NUM_RS;
            end
            if (!found && !rs_busy[cand]) begin
                found   = 1'b1;
                sel_idx = SEL_W'(cand);
            end
        end
    end

    // Remember the last allocated station for the next search.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            rr_ptr <= SEL_W'(NUM_RS - 1);
        end else if (state == S_ALLOC && found) begin
            rr_ptr <= sel_idx;
        end
    end
`else
    // Fixed priority: scan from the top so the lowest free index wins last.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!rs_busy[i]) begin
                found   = 1'b1;
                sel_idx = SEL_W'(i);
            end
        end
    end
`endif

    // FSM state register; CLR aborts any instruction in flight.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state and the issue handshake pulses.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        next_state = state;
        q_rd       = 1'b0;
        rs_start   = '0;
        rf_wren    = 1'b0;
        rf_wr_tag  = '0;
        case (state)
            S_IDLE: begin
                if (!q_empty) begin
                    // q_rd is combinational, so mask it while CLR holds the
                    // block in reset and keep every output low.
                    q_rd       = !CLR;
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                next_state = S_READ;
            end
            S_READ: begin
                next_state = S_ALLOC;
            end
            S_ALLOC: begin
                if (found) begin
                    rs_start   = NUM_RS'(1) << sel_idx;
                    rf_wren    = 1'b1;
                    rf_wr_tag  = TAG_W'(sel_idx) + TAG_W'(1);
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Instruction register, operand latches with CDB snooping, counters.
    always_ff @(posedge CLK or posedge CLR) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register here samples the values from before the clock edge.
        if (CLR) begin
            ir         <= '0;
            op0        <= '0;
            op1        <= '0;
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (state == S_LOAD) begin
                ir <= q_instr;
            end
            // Sources are read before the rename so dest == src keeps the
            // old producer tag or value.
            if (state == S_READ) begin
                op0 <= rf_op0;
                op1 <= rf_op1;
            end
            if (state == S_ALLOC) begin
                op0 <= op0_byp;
                op1 <= op1_byp;
            end
            if (state == S_ALLOC && found) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
            if (state == S_ALLOC && !found && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios plus randomized
// instructions, checked against a transaction-level model of the issue stage
// (operand read + CDB snoop rule, station choice, counters).
module tb_issue_unit;

    localparam int DATA_W    = 16;
    localparam int INSTR_W   = 16;
    localparam int NUM_RS    = 4;
    localparam int TAG_W     = 3;
    localparam int REG_IDX_W = 3;

    logic                 CLK = 1'b0;
    logic                 CLR;
    logic                 q_empty;
    logic                 q_rd;
    logic [INSTR_W-1:0]   q_instr;
    logic [REG_IDX_W-1:0] rf_rd0_idx;
    logic [REG_IDX_W-1:0] rf_rd1_idx;
    logic [TAG_W-1:0]     rf_rd0_tag;
    logic [TAG_W-1:0]     rf_rd1_tag;
    logic [DATA_W-1:0]    rf_rd0_data;
    logic [DATA_W-1:0]    rf_rd1_data;
    logic                 rf_wren;
    logic [REG_IDX_W-1:0] rf_wr_idx;
    logic [TAG_W-1:0]     rf_wr_tag;
    logic [NUM_RS-1:0]    rs_busy;
    logic [NUM_RS-1:0]    rs_start;
    logic [INSTR_W-1:0]   rs_instr;
    logic [TAG_W-1:0]     rs_tag0;
    logic [TAG_W-1:0]     rs_tag1;
    logic [DATA_W-1:0]    rs_data0;
    logic [DATA_W-1:0]    rs_data1;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]    cdb_data;
    logic [15:0]          issued_cnt;
    logic [15:0]          stall_cnt;

    issue_unit #(
        .DATA_W   (DATA_W),
        .INSTR_W  (INSTR_W),
        .NUM_RS   (NUM_RS),
        .TAG_W    (TAG_W),
        .REG_IDX_W(REG_IDX_W)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .q_empty    (q_empty),
        .q_rd       (q_rd),
        .q_instr    (q_instr),
        .rf_rd0_idx (rf_rd0_idx),
        .rf_rd1_idx (rf_rd1_idx),
        .rf_rd0_tag (rf_rd0_tag),
        .rf_rd1_tag (rf_rd1_tag),
        .rf_rd0_data(rf_rd0_data),
        .rf_rd1_data(rf_rd1_data),
        .rf_wren    (rf_wren),
        .rf_wr_idx  (rf_wr_idx),
        .rf_wr_tag  (rf_wr_tag),
        .rs_busy    (rs_busy),
        .rs_start   (rs_start),
        .rs_instr   (rs_instr),
        .rs_tag0    (rs_tag0),
        .rs_tag1    (rs_tag1),
        .rs_data0   (rs_data0),
        .rs_data1   (rs_data1),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Register file model: combinational read of tag and value.
    logic [TAG_W-1:0]  rf_tag_m  [8];
    logic [DATA_W-1:0] rf_data_m [8];
    assign rf_rd0_tag  = rf_tag_m[rf_rd0_idx];
    assign rf_rd1_tag  = rf_tag_m[rf_rd1_idx];
    assign rf_rd0_data = rf_data_m[rf_rd0_idx];
    assign rf_rd1_data = rf_data_m[rf_rd1_idx];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_last;
    int m_issued;
    int m_stall;

    // Per-instruction scenario knobs.
    bit               cfg_rand;
    int               cfg_stall;
    logic [3:0]       cfg_free;
    int               cfg_cdb_k;
    logic [TAG_W-1:0] cfg_cdb_tag;
    logic [DATA_W-1:0] cfg_cdb_data;
    int               cfg_abort_k;

    // Values observed in the most recent start cycle.
    logic [3:0]        obs_start;
    logic [TAG_W-1:0]  obs_wr_tag;
    logic [TAG_W-1:0]  obs_tag0;
    logic [DATA_W-1:0] obs_data0;
    logic [DATA_W-1:0] obs_data1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Station choice from the allocation policy and the model pointer.
    function automatic int pick(input logic [3:0] busy);
        int res;
        res = -1;
`ifdef ISSUE_RR_ALLOC_EN
        for (int k = 1; k <= NUM_RS; k++) begin
            int c;
            c = (m_last + k) % NUM_RS;
            if (res < 0 && !busy[c]) res = c;
        end
`else
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!busy[i]) res = i;
        end
`endif
        return res;
    endfunction

    task automatic model_reset();
        m_last   = NUM_RS - 1;
        m_issued = 0;
        m_stall  = 0;
    endtask

    task automatic do_reset();
        CLR       = 1'b1;
        q_empty   = 1'b1;
        rs_busy   = '0;
        cdb_valid = 1'b0;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        model_reset();
    endtask

    // Issue one instruction from an idle DUT; cycle k=0 is the pop cycle.
    task automatic run_instr(input logic [15:0] instr);
        logic [TAG_W-1:0]  t0, t1;
        logic [DATA_W-1:0] d0, d1;
        logic [3:0]        busy;
        int k_exp, sel, src0, src1;
        src0  = int'(instr[5:3]);
        src1  = int'(instr[8:6]);
        k_exp = 3 + cfg_stall;
        t0 = '0; t1 = '0; d0 = '0; d1 = '0;
        for (int k = 0; k <= k_exp; k++) begin
            @(negedge CLK);
            q_empty   = (k == 0) ? 1'b0 : 1'b1;
            q_instr   = (k == 1) ? instr : 16'($urandom);
            cdb_valid = 1'b0;
            cdb_tag   = TAG_W'($urandom);
            cdb_data  = DATA_W'($urandom);
            if (k == 0 && cfg_rand) begin
                for (int r = 0; r < 8; r++) begin
                    rf_tag_m[r]  = TAG_W'($urandom_range(0, 4));
                    rf_data_m[r] = DATA_W'($urandom);
                end
            end
            if (k < 3)          busy = 4'($urandom);
            else if (k < k_exp) busy = 4'hF;
            else                busy = cfg_free;
            rs_busy = busy;
            if (cfg_rand) begin
                if ($urandom_range(0, 2) == 0) begin
                    cdb_valid = 1'b1;
                    case ($urandom_range(0, 2))
                        0:       cdb_tag = rf_tag_m[src0];
                        1:       cdb_tag = rf_tag_m[src1];
                        default: cdb_tag = TAG_W'($urandom);
                    endcase
                end
            end else if (k == cfg_cdb_k) begin
                cdb_valid = 1'b1;
                cdb_tag   = cfg_cdb_tag;
                cdb_data  = cfg_cdb_data;
            end
            #1;
            // Operand model: read in READ, then snoop every later cycle.
            if (k == 2) begin
                t0 = rf_tag_m[src0]; d0 = rf_data_m[src0];
                t1 = rf_tag_m[src1]; d1 = rf_data_m[src1];
            end
            if (k >= 2 && cdb_valid) begin
                if (t0 != 0 && cdb_tag == t0) begin t0 = '0; d0 = cdb_data; end
                if (t1 != 0 && cdb_tag == t1) begin t1 = '0; d1 = cdb_data; end
            end
            check("q_rd", 32'(q_rd), 32'(k == 0));
            if (k == 0) begin
                check("issued_cnt", 32'(issued_cnt), 32'(m_issued % 65536));
                check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            end
            if (k == 2) begin
                check("rf_rd0_idx", 32'(rf_rd0_idx), 32'(instr[5:3]));
                check("rf_rd1_idx", 32'(rf_rd1_idx), 32'(instr[8:6]));
            end
            if (k < k_exp) begin
                check("rs_start_quiet", 32'(rs_start), 32'(0));
                check("rf_wren_quiet", 32'(rf_wren), 32'(0));
                if (k >= 3 && m_stall < 65535) m_stall++;
                if (k == cfg_abort_k) begin
                    CLR = 1'b1;
                    #1;
                    check("rst_q_rd", 32'(q_rd), 32'(0));
                    check("rst_rs_start", 32'(rs_start), 32'(0));
                    check("rst_rf_wren", 32'(rf_wren), 32'(0));
                    check("rst_rf_wr_tag", 32'(rf_wr_tag), 32'(0));
                    check("rst_rf_wr_idx", 32'(rf_wr_idx), 32'(0));
                    check("rst_rf_rd1_idx", 32'(rf_rd1_idx), 32'(0));
                    check("rst_rs_instr", 32'(rs_instr), 32'(0));
                    check("rst_rs_tag0", 32'(rs_tag0), 32'(0));
                    check("rst_rs_data0", 32'(rs_data0), 32'(0));
                    check("rst_rs_tag1", 32'(rs_tag1), 32'(0));
                    check("rst_rs_data1", 32'(rs_data1), 32'(0));
                    check("rst_issued_cnt", 32'(issued_cnt), 32'(0));
                    check("rst_stall_cnt", 32'(stall_cnt), 32'(0));
                    return;
                end
            end else begin
                sel = pick(busy);
                check("rs_start", 32'(rs_start), 1 << sel);
                check("rf_wren", 32'(rf_wren), 32'(1));
                check("rf_wr_tag", 32'(rf_wr_tag), sel + 1);
                check("rf_wr_idx", 32'(rf_wr_idx), 32'(instr[5:3]));
                check("rs_instr", 32'(rs_instr), 32'(instr));
                check("rs_tag0", 32'(rs_tag0), 32'(t0));
                check("rs_data0", 32'(rs_data0), 32'(d0));
                check("rs_tag1", 32'(rs_tag1), 32'(t1));
                check("rs_data1", 32'(rs_data1), 32'(d1));
                obs_start  = rs_start;
                obs_wr_tag = rf_wr_tag;
                obs_tag0   = rs_tag0;
                obs_data0  = rs_data0;
                obs_data1  = rs_data1;
                m_last = sel;
                m_issued++;
            end
        end
    endtask

    task automatic set_directed(input int stall, input logic [3:0] free_pat, input int cdb_k);
        cfg_rand    = 1'b0;
        cfg_stall   = stall;
        cfg_free    = free_pat;
        cfg_cdb_k   = cdb_k;
        cfg_abort_k = -1;
    endtask

    logic [TAG_W-1:0] pol_tags [5];
    int               exp_tags [5];

    initial begin
        CLR       = 1'b1;
        q_empty   = 1'b0;
        q_instr   = '0;
        rs_busy   = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        for (int r = 0; r < 8; r++) begin
            rf_tag_m[r]  = '0;
            rf_data_m[r] = DATA_W'(16'h0100 + r);
        end
        cfg_cdb_tag  = '0;
        cfg_cdb_data = '0;
        set_directed(0, 4'b0000, -1);
        model_reset();

        // Reset state, with a non-empty queue to show q_rd stays low.
        #3;
        check("reset_q_rd", 32'(q_rd), 32'(0));
        check("reset_rs_start", 32'(rs_start), 32'(0));
        check("reset_rf_wren", 32'(rf_wren), 32'(0));
        check("reset_rs_instr", 32'(rs_instr), 32'(0));
        check("reset_issued", 32'(issued_cnt), 32'(0));
        check("reset_stall", 32'(stall_cnt), 32'(0));
        do_reset();

        // Basic issue.
        rf_tag_m[3] = '0; rf_data_m[3] = 16'h1234;
        rf_tag_m[1] = '0; rf_data_m[1] = 16'h00AA;
        set_directed(0, 4'b0000, -1);
        run_instr(16'h0058);
        check("basic_start", 32'(obs_start), 32'h1);
        check("basic_data0", 32'(obs_data0), 32'h1234);
        check("basic_data1", 32'(obs_data1), 32'h00AA);
        check("basic_wr_tag", 32'(obs_wr_tag), 32'd1);
        @(negedge CLK); q_empty = 1'b1; #1;
        check("basic_issued", 32'(issued_cnt), 32'd1);

        // Stall: five full cycles, then only station 2 free.
        set_directed(5, 4'b1011, -1);
        run_instr(16'h0058);
        check("stall_start", 32'(obs_start), 32'b0100);
        check("stall_wr_tag", 32'(obs_wr_tag), 32'd3);
        @(negedge CLK); q_empty = 1'b1; #1;
        check("stall_cnt_5", 32'(stall_cnt), 32'd5);

        // CDB bypass: during READ, mid-stall, and in the start cycle.
        rf_tag_m[5] = 3'd2; rf_data_m[5] = 16'h1111;
        rf_tag_m[2] = '0;   rf_data_m[2] = 16'h2222;
        cfg_cdb_tag = 3'd2; cfg_cdb_data = 16'hBEEF;
        for (int v = 0; v < 3; v++) begin
            case (v)
                0:       set_directed(0, 4'b0000, 2);
                1:       set_directed(3, 4'b0000, 4);
                default: set_directed(1, 4'b0000, 4);
            endcase
            run_instr(16'h00A8);
            check("bypass_tag0", 32'(obs_tag0), 32'd0);
            check("bypass_data0", 32'(obs_data0), 32'hBEEF);
        end

        // Empty queue: no pop, FSM parked in IDLE (next pop is immediate).
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            q_empty   = 1'b1;
            cdb_valid = 1'b0;
            rs_busy   = 4'($urandom);
            #1;
            check("empty_q_rd", 32'(q_rd), 32'(0));
            check("empty_rs_start", 32'(rs_start), 32'(0));
        end
        set_directed(0, 4'b0000, -1);
        run_instr(16'h0191);

        // Allocation policy: five back-to-back issues from reset.
        do_reset();
        set_directed(0, 4'b0000, -1);
`ifdef ISSUE_RR_ALLOC_EN
        exp_tags = '{1, 2, 3, 4, 1};
`else
        exp_tags = '{1, 1, 1, 1, 1};
`endif
        for (int n = 0; n < 5; n++) begin
            run_instr(16'($urandom));
            pol_tags[n] = obs_wr_tag;
        end
        for (int n = 0; n < 5; n++) begin
            check("policy_tag", 32'(pol_tags[n]), exp_tags[n]);
        end

        // Reset while stalled in ALLOC.
        set_directed(4, 4'b0000, -1);
        cfg_abort_k = 5;
        run_instr(16'h01D0);
        @(negedge CLK);
        CLR = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            q_empty   = 1'b1;
            rs_busy   = '0;
            cdb_valid = 1'b0;
            #1;
            check("post_rst_start", 32'(rs_start), 32'(0));
            check("post_rst_wren", 32'(rf_wren), 32'(0));
        end
        set_directed(0, 4'b0000, -1);
        run_instr(16'h01D0);
        check("post_rst_wr_tag", 32'(obs_wr_tag), 32'd1);

        // Randomized instructions.
        for (int n = 0; n < 40; n++) begin
            cfg_rand    = 1'b1;
            cfg_stall   = $urandom_range(0, 3);
            cfg_free    = 4'($urandom);
            if (cfg_free == 4'hF) cfg_free = 4'b0111;
            cfg_cdb_k   = -1;
            cfg_abort_k = -1;
            run_instr(16'($urandom));
        end
        @(negedge CLK); q_empty = 1'b1; #1;
        check("final_issued", 32'(issued_cnt), 32'(m_issued % 65536));
        check("final_stall", 32'(stall_cnt), 32'(m_stall));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the stimulus is bounded, so this only fires on a broken run.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
